uart_reporter: RTL and testbench

UART transmitter that sends the logic core's 32-bit data word and 4-bit layout code to a host over the board's USB-UART line. A one-cycle send pulse, typically the conditioned button pulse from the input conditioner, latches `data_i`/`layout_i`. The block then serializes a fixed 12-character ASCII line. It sits beside the display path, taking the same `data`/`layout` nets, and drives the FPGA's UART TX pin, making it the outbound counterpart of the board-input receiver.

---
 rtl/uart_reporter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_reporter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reporter.sv
// Serializes "L:DDDDDDDD\r\n" (layout, data in uppercase hex) as 8N1 UART.
// Define UART_REPORTER_PARITY_EN for 8E1 framing (adds a PARITY state).
module uart_reporter #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        send_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  layout_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_TICK =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_CHAR = 4'd11;

`ifdef UART_REPORTER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_baud;
  logic [CNT_W-1:0] w_baud_n;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_n;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_n;
  logic             r_tx;
  logic             w_tx_n;
  logic             r_busy;
  logic             w_busy_n;
  logic             r_done;
  logic             w_done_n;
  logic             w_latch;
  logic [31:0]      r_data;
  logic [3:0]       r_layout;

  logic             w_tick;
  logic [2:0]       w_bit_nxt;
  logic [2:0]       w_sel;
  logic [31:0]      w_shift;
  logic [7:0]       w_char;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  assign w_tick    = (r_baud == LAST_TICK);
  assign w_bit_nxt = r_bit + 3'd1;

  // Chars 2..9 map to data nibbles 7..0; shift the wanted one to the top.
  assign w_sel   = r_idx[2:0] - 3'd2;
  assign w_shift = r_data << {w_sel, 2'b00};

  always_comb begin
    w_char = 8'h0A;
    unique case (1'b1)
      (r_idx == 4'd0):
        w_char = f_hex(r_layout);
      (r_idx == 4'd1):
        w_char = 8'h3A;
      (r_idx >= 4'd2 && r_idx <= 4'd9):
        w_char = f_hex(w_shift[31:28]);
      (r_idx == 4'd10):
        w_char = 8'h0D;
      default:
        w_char = 8'h0A;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud + CNT_W'(1);
    w_bit_n   = r_bit;
    w_idx_n   = r_idx;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_latch   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
        w_baud_n = '0;
        if (send_i) begin
          w_latch   = 1'b1;
          w_state_n = S_START;
          w_idx_n   = 4'd0;
          w_tx_n    = 1'b0;
          w_busy_n  = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_n = S_DATA;
          w_baud_n  = '0;
          w_bit_n   = 3'd0;
          w_tx_n    = w_char[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
`ifdef UART_REPORTER_PARITY_EN
            w_state_n = S_PARITY;
            w_tx_n    = ^w_char;
`else
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
`endif
          end else begin
            w_bit_n = w_bit_nxt;
            w_tx_n  = w_char[w_bit_nxt];
          end
        end
      end
`ifdef UART_REPORTER_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_state_n = S_STOP;
          w_baud_n  = '0;
          w_tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_baud_n = '0;
          if (r_idx != LAST_CHAR) begin
            w_idx_n   = r_idx + 4'd1;
            w_state_n = S_START;
            w_tx_n    = 1'b0;
          end else begin
            w_done_n = 1'b1;
            // A request on the completing edge starts the next line gap-free.
            if (send_i) begin
              w_latch   = 1'b1;
              w_idx_n   = 4'd0;
              w_state_n = S_START;
              w_tx_n    = 1'b0;
            end else begin
              w_state_n = S_IDLE;
              w_busy_n  = 1'b0;
              w_tx_n    = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_baud_n  = '0;
        w_tx_n    = 1'b1;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_idx    <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_layout <= '0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_idx   <= w_idx_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      if (w_latch) begin
        r_data   <= data_i;
        r_layout <= layout_i;
      end
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_uart_reporter.sv
// Directed bench for uart_reporter at CLKS_PER_BIT=10.
// A UART receiver task decodes tx_o at mid-bit and compares whole lines.
module tb_uart_reporter;

  localparam int CPB = 10;
`ifdef UART_REPORTER_PARITY_EN
  localparam int LINE_CYC = 1320;
`else
  localparam int LINE_CYC = 1200;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        send = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  layout = '0;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t_done = 0;
  int t_acc = 0;

  uart_reporter #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .send_i  (send),
    .data_i  (data),
    .layout_i(layout),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      t_done = cyc;
    end
  end

  task automatic rx_byte(output logic [7:0] b, output logic err);
    int n;
    err = 1'b0;
    b = '0;
    n = 0;
    while (tx_o !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx_o !== 1'b0) begin
      err = 1'b1;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    if (tx_o !== 1'b0) err = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx_o;
    end
`ifdef UART_REPORTER_PARITY_EN
    repeat (CPB) @(negedge clk);
    if (tx_o !== ^b) err = 1'b1;
`endif
    repeat (CPB) @(negedge clk);
    if (tx_o !== 1'b1) err = 1'b1;
  endtask

  task automatic rx_line(output logic [95:0] line, output logic err);
    logic [7:0] b;
    logic e;
    err = 1'b0;
    line = '0;
    for (int k = 0; k < 12; k++) begin
      rx_byte(b, e);
      line = {line[87:0], b};
      if (e) begin
        err = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_send(input logic [31:0] d, input logic [3:0] l);
    @(negedge clk);
    data = d;
    layout = l;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(output logic seen);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    seen = (done_o === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({tx_o, busy_o, done_o} !== 3'b100) begin
      $display("FAIL reset_outputs got %b want 100", {tx_o, busy_o, done_o});
    end else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({tx_o, busy_o, done_o} !== 3'b100) begin
      $display("FAIL idle_after_reset got %b want 100", {tx_o, busy_o, done_o});
    end else n_pass++;
  endtask

  task automatic test_basic_line;
    logic [95:0] line;
    logic [95:0] exp;
    logic err;
    logic seen;
    int d0;
    exp = {"3:DEADBEEF", 8'h0D, 8'h0A};
    d0 = done_cnt;
    pulse_send(32'hDEADBEEF, 4'h3);
    n_total++;
    if ({tx_o, busy_o} !== 2'b01) begin
      $display("FAIL basic_start got tx,busy=%b want 01", {tx_o, busy_o});
    end else n_pass++;
    rx_line(line, err);
    n_total++;
    if (err || line !== exp) begin
      $display("FAIL basic_line got %h err=%0b want %h", line, err, exp);
    end else n_pass++;
    wait_done(seen);
    @(negedge clk);
    n_total++;
    if (!seen || t_done - t_acc != LINE_CYC) begin
      $display("FAIL basic_done_time got %0d want %0d", t_done - t_acc, LINE_CYC);
    end else n_pass++;
    n_total++;
    if (done_cnt - d0 != 1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL basic_done_pulse got cnt=%0d done=%b busy=%b want 1 0 0",
               done_cnt - d0, done_o, busy_o);
    end else n_pass++;
  endtask

  task automatic test_latch_ignore;
    logic [95:0] line;
    logic [95:0] exp;
    logic err;
    logic seen;
    int d0;
    exp = {"3:DEADBEEF", 8'h0D, 8'h0A};
    d0 = done_cnt;
    pulse_send(32'hDEADBEEF, 4'h3);
    fork
      rx_line(line, err);
      begin
        repeat (99) @(negedge clk);
        data = 32'h0;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    join
    n_total++;
    if (err || line !== exp) begin
      $display("FAIL latch_line got %h err=%0b want %h", line, err, exp);
    end else n_pass++;
    wait_done(seen);
    repeat (300) @(negedge clk);
    n_total++;
    if (!seen || done_cnt - d0 != 1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
      $display("FAIL ignore_no_second got cnt=%0d busy=%b tx=%b want 1 0 1",
               done_cnt - d0, busy_o, tx_o);
    end else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [95:0] line;
    logic [95:0] exp1;
    logic [95:0] exp2;
    logic err;
    logic seen;
    exp1 = {"3:DEADBEEF", 8'h0D, 8'h0A};
    exp2 = {"F:0123ABCD", 8'h0D, 8'h0A};
    pulse_send(32'hDEADBEEF, 4'h3);
    rx_line(line, err);
    n_total++;
    if (err || line !== exp1) begin
      $display("FAIL b2b_first got %h err=%0b want %h", line, err, exp1);
    end else n_pass++;
    wait_done(seen);
    data = 32'h0123ABCD;
    layout = 4'hF;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    t_acc = cyc;
    n_total++;
    if (!seen || {tx_o, busy_o} !== 2'b01) begin
      $display("FAIL b2b_restart got seen=%b tx,busy=%b want 1 01",
               seen, {tx_o, busy_o});
    end else n_pass++;
    rx_line(line, err);
    n_total++;
    if (err || line !== exp2) begin
      $display("FAIL b2b_second got %h err=%0b want %h", line, err, exp2);
    end else n_pass++;
    wait_done(seen);
    @(negedge clk);
    n_total++;
    if (!seen || t_done - t_acc != LINE_CYC) begin
      $display("FAIL b2b_done_time got %0d want %0d", t_done - t_acc, LINE_CYC);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_line;
    logic [95:0] line;
    logic [95:0] exp;
    logic err;
    logic seen;
    int d0;
    exp = {"3:DEADBEEF", 8'h0D, 8'h0A};
    d0 = done_cnt;
    pulse_send(32'hDEADBEEF, 4'h3);
    repeat (436) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({tx_o, busy_o, done_o} !== 3'b100) begin
      $display("FAIL midreset_outputs got %b want 100", {tx_o, busy_o, done_o});
    end else n_pass++;
    repeat (1400) @(negedge clk);
    n_total++;
    if (done_cnt != d0 || tx_o !== 1'b1) begin
      $display("FAIL midreset_no_done got cnt=%0d tx=%b want 0 1",
               done_cnt - d0, tx_o);
    end else n_pass++;
    pulse_send(32'hDEADBEEF, 4'h3);
    rx_line(line, err);
    wait_done(seen);
    @(negedge clk);
    n_total++;
    if (err || !seen || line !== exp || done_cnt - d0 != 1) begin
      $display("FAIL midreset_recover got %h err=%0b cnt=%0d want %h 1",
               line, err, done_cnt - d0, exp);
    end else n_pass++;
  endtask

  task automatic test_send_with_reset;
    @(negedge clk);
    data = 32'h12345678;
    send = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    send = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_total++;
    if ({tx_o, busy_o} !== 2'b10) begin
      $display("FAIL reset_wins got tx,busy=%b want 10", {tx_o, busy_o});
    end else n_pass++;
  endtask

  task automatic test_edge_values;
    logic [95:0] line;
    logic [95:0] exp;
    logic err;
    logic low_seen;
    exp = {"0:FFFFFFFF", 8'h0D, 8'h0A};
    low_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) low_seen = 1'b1;
    end
    n_total++;
    if (low_seen) begin
      $display("FAIL idle_line got low=%b want 0", low_seen);
    end else n_pass++;
    pulse_send(32'hFFFFFFFF, 4'h0);
    rx_line(line, err);
    n_total++;
    if (err || line !== exp) begin
      $display("FAIL edge_line got %h err=%0b want %h", line, err, exp);
    end else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic_line;
    test_latch_ignore;
    test_back_to_back;
    test_reset_mid_line;
    test_send_with_reset;
    test_edge_values;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
